reorder_buffer: RTL and testbench

//  16-entry circular reorder buffer. Allocates a ROB position per issued instruction and records
//  out-of-order results from ALU and LSB. Retires strictly in program order, driving the commit

---
 rtl/reorder_buffer.sv | 224 ++++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 16-entry circular reorder buffer with in-order commit and mispredict rollback
// Results arrive out of order from ALU/LSB; entries retire one per cycle from the head.
module reorder_buffer #(
  parameter int ROB_SIZE_LOG = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rdy_i,
  output logic                    full_o,
  input  logic                    issue_i,
  input  logic [4:0]              issue_rd_i,
  input  logic                    issue_is_br_i,
  input  logic                    issue_is_store_i,
  input  logic                    issue_pred_jump_i,
  input  logic                    issue_ready_i,
  input  logic [31:0]             issue_val_i,
  output logic [ROB_SIZE_LOG-1:0] issue_rob_pos_o,
  input  logic                    alu_valid_i,
  input  logic [ROB_SIZE_LOG-1:0] alu_rob_pos_i,
  input  logic [31:0]             alu_val_i,
  input  logic                    alu_real_jump_i,
  input  logic [31:0]             alu_target_pc_i,
  input  logic                    lsb_valid_i,
  input  logic [ROB_SIZE_LOG-1:0] lsb_rob_pos_i,
  input  logic [31:0]             lsb_val_i,
  input  logic [ROB_SIZE_LOG-1:0] q1_rob_pos_i,
  output logic                    q1_ready_o,
  output logic [31:0]             q1_val_o,
  input  logic [ROB_SIZE_LOG-1:0] q2_rob_pos_i,
  output logic                    q2_ready_o,
  output logic [31:0]             q2_val_o,
  output logic                    commit_o,
  output logic [4:0]              commit_rd_o,
  output logic [31:0]             commit_val_o,
  output logic [ROB_SIZE_LOG-1:0] commit_rob_pos_o,
  output logic                    commit_store_o,
  output logic                    rollback_o,
  output logic [31:0]             rollback_pc_o
);

  localparam int W        = ROB_SIZE_LOG;
  localparam int ROB_SIZE = 1 << ROB_SIZE_LOG;

  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [W:0]   count_q, count_d;

  logic        ready_q [ROB_SIZE];
  logic        ready_d [ROB_SIZE];
  logic [4:0]  rd_q    [ROB_SIZE];
  logic [4:0]  rd_d    [ROB_SIZE];
  logic [31:0] val_q   [ROB_SIZE];
  logic [31:0] val_d   [ROB_SIZE];
  logic        is_br_q [ROB_SIZE];
  logic        is_br_d [ROB_SIZE];
  logic        is_st_q [ROB_SIZE];
  logic        is_st_d [ROB_SIZE];
  logic        pred_q  [ROB_SIZE];
  logic        pred_d  [ROB_SIZE];
  logic        real_q  [ROB_SIZE];
  logic        real_d  [ROB_SIZE];
  logic [31:0] tpc_q   [ROB_SIZE];
  logic [31:0] tpc_d   [ROB_SIZE];

  logic          commit_q, commit_d, commit_store_q, commit_store_d;
  logic [4:0]    commit_rd_q, commit_rd_d;
  logic [31:0]   commit_val_q, commit_val_d;
  logic [W-1:0]  commit_pos_q, commit_pos_d;
  logic          rollback_q, rollback_d;
  logic [31:0]   rollback_pc_q, rollback_pc_d;

  logic full, accept, do_commit, mispredict;

  assign full       = (count_q == (W+1)'(ROB_SIZE));
  assign accept     = issue_i && !full && !rollback_q;
  assign do_commit  = (count_q != '0) && ready_q[head_q] && !rollback_q;
  assign mispredict = do_commit && is_br_q[head_q] && (real_q[head_q] != pred_q[head_q]);

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    ready_d       = ready_q;
    rd_d          = rd_q;
    val_d         = val_q;
    is_br_d       = is_br_q;
    is_st_d       = is_st_q;
    pred_d        = pred_q;
    real_d        = real_q;
    tpc_d         = tpc_q;
    commit_d      = commit_q;
    commit_store_d = commit_store_q;
    commit_rd_d   = commit_rd_q;
    commit_val_d  = commit_val_q;
    commit_pos_d  = commit_pos_q;
    rollback_d    = rollback_q;
    rollback_pc_d = rollback_pc_q;

    // rdy low freezes everything, so pending pulses are seen exactly once by consumers.
    if (rdy_i) begin
      commit_d       = 1'b0;
      commit_store_d = 1'b0;
      rollback_d     = 1'b0;
      if (!rollback_q) begin
        if (lsb_valid_i) begin
          ready_d[lsb_rob_pos_i] = 1'b1;
          val_d[lsb_rob_pos_i]   = lsb_val_i;
        end
        if (alu_valid_i) begin
          ready_d[alu_rob_pos_i] = 1'b1;
          val_d[alu_rob_pos_i]   = alu_val_i;
          real_d[alu_rob_pos_i]  = alu_real_jump_i;
          tpc_d[alu_rob_pos_i]   = alu_target_pc_i;
        end
        if (accept) begin
          ready_d[tail_q] = issue_ready_i;
          rd_d[tail_q]    = issue_rd_i;
          val_d[tail_q]   = issue_val_i;
          is_br_d[tail_q] = issue_is_br_i;
          is_st_d[tail_q] = issue_is_store_i;
          pred_d[tail_q]  = issue_pred_jump_i;
          real_d[tail_q]  = 1'b0;
          tpc_d[tail_q]   = '0;
          tail_d          = tail_q + W'(1);
        end
        if (do_commit) begin
          commit_d        = 1'b1;
          commit_store_d  = is_st_q[head_q];
          commit_rd_d     = is_st_q[head_q] ? 5'd0 : rd_q[head_q];
          commit_val_d    = val_q[head_q];
          commit_pos_d    = head_q;
          ready_d[head_q] = 1'b0;
          head_d          = head_q + W'(1);
        end
        count_d = count_q + (W+1)'(accept) - (W+1)'(do_commit);
        // Flush overrides every other update made in this cycle.
        if (mispredict) begin
          rollback_d    = 1'b1;
          rollback_pc_d = tpc_q[head_q];
          head_d        = '0;
          tail_d        = '0;
          count_d       = '0;
          for (int i = 0; i < ROB_SIZE; i++) ready_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_q       <= 1'b0;
      commit_store_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_val_q   <= '0;
      commit_pos_q   <= '0;
      rollback_q     <= 1'b0;
      rollback_pc_q  <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        ready_q[i] <= 1'b0;
        rd_q[i]    <= '0;
        val_q[i]   <= '0;
        is_br_q[i] <= 1'b0;
        is_st_q[i] <= 1'b0;
        pred_q[i]  <= 1'b0;
        real_q[i]  <= 1'b0;
        tpc_q[i]   <= '0;
      end
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_q       <= commit_d;
      commit_store_q <= commit_store_d;
      commit_rd_q    <= commit_rd_d;
      commit_val_q   <= commit_val_d;
      commit_pos_q   <= commit_pos_d;
      rollback_q     <= rollback_d;
      rollback_pc_q  <= rollback_pc_d;
      ready_q        <= ready_d;
      rd_q           <= rd_d;
      val_q          <= val_d;
      is_br_q        <= is_br_d;
      is_st_q        <= is_st_d;
      pred_q         <= pred_d;
      real_q         <= real_d;
      tpc_q          <= tpc_d;
    end
  end

  // Operand bypass: a same-cycle writeback wins over stored state, ALU over LSB.
  always_comb begin
    q1_ready_o = ready_q[q1_rob_pos_i];
    q1_val_o   = val_q[q1_rob_pos_i];
    if (alu_valid_i && alu_rob_pos_i == q1_rob_pos_i) begin
      q1_ready_o = 1'b1;
      q1_val_o   = alu_val_i;
    end else if (lsb_valid_i && lsb_rob_pos_i == q1_rob_pos_i) begin
      q1_ready_o = 1'b1;
      q1_val_o   = lsb_val_i;
    end
    q2_ready_o = ready_q[q2_rob_pos_i];
    q2_val_o   = val_q[q2_rob_pos_i];
    if (alu_valid_i && alu_rob_pos_i == q2_rob_pos_i) begin
      q2_ready_o = 1'b1;
      q2_val_o   = alu_val_i;
    end else if (lsb_valid_i && lsb_rob_pos_i == q2_rob_pos_i) begin
      q2_ready_o = 1'b1;
      q2_val_o   = lsb_val_i;
    end
  end

  assign full_o           = full;
  assign issue_rob_pos_o  = tail_q;
  assign commit_o         = commit_q;
  assign commit_rd_o      = commit_rd_q;
  assign commit_val_o     = commit_val_q;
  assign commit_rob_pos_o = commit_pos_q;
  assign commit_store_o   = commit_store_q;
  assign rollback_o       = rollback_q;
  assign rollback_pc_o    = rollback_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed table-driven bench for reorder_buffer
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n, rdy, full;
  logic        issue, issue_is_br, issue_is_store, issue_pred_jump, issue_ready;
  logic [4:0]  issue_rd;
  logic [31:0] issue_val;
  logic [3:0]  issue_rob_pos;
  logic        alu_valid, alu_real_jump;
  logic [3:0]  alu_rob_pos;
  logic [31:0] alu_val, alu_target_pc;
  logic        lsb_valid;
  logic [3:0]  lsb_rob_pos;
  logic [31:0] lsb_val;
  logic [3:0]  q1_rob_pos, q2_rob_pos;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_val, q2_val;
  logic        commit, commit_store, rollback;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val, rollback_pc;
  logic [3:0]  commit_rob_pos;

  int n_tests = 0;
  int n_fail  = 0;

  reorder_buffer dut (
    .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy), .full_o(full),
    .issue_i(issue), .issue_rd_i(issue_rd), .issue_is_br_i(issue_is_br),
    .issue_is_store_i(issue_is_store), .issue_pred_jump_i(issue_pred_jump),
    .issue_ready_i(issue_ready), .issue_val_i(issue_val), .issue_rob_pos_o(issue_rob_pos),
    .alu_valid_i(alu_valid), .alu_rob_pos_i(alu_rob_pos), .alu_val_i(alu_val),
    .alu_real_jump_i(alu_real_jump), .alu_target_pc_i(alu_target_pc),
    .lsb_valid_i(lsb_valid), .lsb_rob_pos_i(lsb_rob_pos), .lsb_val_i(lsb_val),
    .q1_rob_pos_i(q1_rob_pos), .q1_ready_o(q1_ready), .q1_val_o(q1_val),
    .q2_rob_pos_i(q2_rob_pos), .q2_ready_o(q2_ready), .q2_val_o(q2_val),
    .commit_o(commit), .commit_rd_o(commit_rd), .commit_val_o(commit_val),
    .commit_rob_pos_o(commit_rob_pos), .commit_store_o(commit_store),
    .rollback_o(rollback), .rollback_pc_o(rollback_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        issue;
    logic [4:0]  rd;
    logic        iready;
    logic [31:0] ival;
    logic        alu_v;
    logic [3:0]  alu_pos;
    logic [31:0] alu_v32;
    logic [3:0]  exp_pos;
    logic        exp_commit;
    logic [4:0]  exp_rd;
    logic [31:0] exp_val;
    logic [3:0]  exp_cpos;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rdy = 1'b1; issue = 1'b0; issue_rd = '0; issue_is_br = 1'b0; issue_is_store = 1'b0;
    issue_pred_jump = 1'b0; issue_ready = 1'b0; issue_val = '0;
    alu_valid = 1'b0; alu_rob_pos = '0; alu_val = '0; alu_real_jump = 1'b0; alu_target_pc = '0;
    lsb_valid = 1'b0; lsb_rob_pos = '0; lsb_val = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_commit", 32'(commit), 32'd0);
    chk("rst_commit_store", 32'(commit_store), 32'd0);
    chk("rst_rollback", 32'(rollback), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_issue_pos", 32'(issue_rob_pos), 32'd0);
    chk("rst_q1_ready", 32'(q1_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic iss(input logic [4:0] rd, input logic rdy_at_issue, input logic [31:0] v,
                     input logic st, input logic br, input logic pj);
    issue = 1'b1; issue_rd = rd; issue_ready = rdy_at_issue; issue_val = v;
    issue_is_store = st; issue_is_br = br; issue_pred_jump = pj;
    step();
    issue = 1'b0; issue_ready = 1'b0; issue_is_store = 1'b0; issue_is_br = 1'b0;
  endtask

  initial begin
    //            iss   rd     rdy   ival      aluv  pos    aluval    epos   ecom  erd    eval      ecpos
    vecs[0]  = '{1'b1, 5'd5, 1'b0, 32'h0,  1'b0, 4'd0, 32'h0,  4'd0, 1'b0, 5'd0, 32'h0,  4'd0};
    vecs[1]  = '{1'b1, 5'd6, 1'b0, 32'h0,  1'b0, 4'd0, 32'h0,  4'd1, 1'b0, 5'd0, 32'h0,  4'd0};
    vecs[2]  = '{1'b1, 5'd7, 1'b0, 32'h0,  1'b0, 4'd0, 32'h0,  4'd2, 1'b0, 5'd0, 32'h0,  4'd0};
    vecs[3]  = '{1'b0, 5'd0, 1'b0, 32'h0,  1'b1, 4'd2, 32'd7,  4'd3, 1'b0, 5'd0, 32'h0,  4'd0};
    vecs[4]  = '{1'b0, 5'd0, 1'b0, 32'h0,  1'b1, 4'd0, 32'd11, 4'd3, 1'b0, 5'd0, 32'h0,  4'd0};
    vecs[5]  = '{1'b0, 5'd0, 1'b0, 32'h0,  1'b1, 4'd1, 32'd13, 4'd3, 1'b1, 5'd5, 32'd11, 4'd0};
    vecs[6]  = '{1'b0, 5'd0, 1'b0, 32'h0,  1'b0, 4'd0, 32'h0,  4'd3, 1'b1, 5'd6, 32'd13, 4'd1};
    vecs[7]  = '{1'b0, 5'd0, 1'b0, 32'h0,  1'b0, 4'd0, 32'h0,  4'd3, 1'b1, 5'd7, 32'd7,  4'd2};
    vecs[8]  = '{1'b0, 5'd0, 1'b0, 32'h0,  1'b0, 4'd0, 32'h0,  4'd3, 1'b0, 5'd0, 32'h0,  4'd0};
    vecs[9]  = '{1'b1, 5'd9, 1'b1, 32'h55, 1'b0, 4'd0, 32'h0,  4'd3, 1'b0, 5'd0, 32'h0,  4'd0};
    vecs[10] = '{1'b0, 5'd0, 1'b0, 32'h0,  1'b0, 4'd0, 32'h0,  4'd4, 1'b1, 5'd9, 32'h55, 4'd3};
    vecs[11] = '{1'b0, 5'd0, 1'b0, 32'h0,  1'b0, 4'd0, 32'h0,  4'd4, 1'b0, 5'd0, 32'h0,  4'd0};

    rst_n = 1'b1; q1_rob_pos = '0; q2_rob_pos = '0;
    idle();
    do_reset();

    // In-order commit of out-of-order ALU results
    for (int i = 0; i < 12; i++) begin
      issue = vecs[i].issue; issue_rd = vecs[i].rd; issue_ready = vecs[i].iready;
      issue_val = vecs[i].ival; alu_valid = vecs[i].alu_v; alu_rob_pos = vecs[i].alu_pos;
      alu_val = vecs[i].alu_v32;
      #1;
      chk($sformatf("v%0d_issue_pos", i), 32'(issue_rob_pos), 32'(vecs[i].exp_pos));
      chk($sformatf("v%0d_full", i), 32'(full), 32'd0);
      step();
      chk($sformatf("v%0d_commit", i), 32'(commit), 32'(vecs[i].exp_commit));
      if (vecs[i].exp_commit) begin
        chk($sformatf("v%0d_commit_rd", i), 32'(commit_rd), 32'(vecs[i].exp_rd));
        chk($sformatf("v%0d_commit_val", i), commit_val, vecs[i].exp_val);
        chk($sformatf("v%0d_commit_pos", i), 32'(commit_rob_pos), 32'(vecs[i].exp_cpos));
      end
    end
    idle();

    // Fill to 16, overflow issue ignored, wrap of tail
    do_reset();
    for (int i = 0; i < 16; i++) iss(5'(i + 1), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_pos_wrap", 32'(issue_rob_pos), 32'd0);
    iss(5'd31, 1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("overflow_full", 32'(full), 32'd1);
    chk("overflow_pos", 32'(issue_rob_pos), 32'd0);
    alu_valid = 1'b1; alu_rob_pos = 4'd0; alu_val = 32'h99;
    step();
    alu_valid = 1'b0;
    chk("wb_no_commit_yet", 32'(commit), 32'd0);
    step();
    chk("wrap_commit", 32'(commit), 32'd1);
    chk("wrap_commit_rd", 32'(commit_rd), 32'd1);
    chk("wrap_commit_val", commit_val, 32'h99);
    chk("wrap_commit_pos", 32'(commit_rob_pos), 32'd0);
    chk("wrap_full_drop", 32'(full), 32'd0);
    chk("wrap_next_pos", 32'(issue_rob_pos), 32'd0);
    iss(5'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("refill_full", 32'(full), 32'd1);
    do_reset();

    // Mispredicted branch at pos3
    iss(5'd1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    iss(5'd2, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    iss(5'd3, 1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
    iss(5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    iss(5'd10, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    alu_valid = 1'b1; alu_rob_pos = 4'd3; alu_val = 32'h0;
    alu_real_jump = 1'b1; alu_target_pc = 32'h1000;
    iss(5'd11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle();
    issue = 1'b1; issue_rd = 5'd20; issue_ready = 1'b1; issue_val = 32'hEE;
    step();
    chk("br_commit", 32'(commit), 32'd1);
    chk("br_commit_pos", 32'(commit_rob_pos), 32'd3);
    chk("br_rollback", 32'(rollback), 32'd1);
    chk("br_rollback_pc", rollback_pc, 32'h1000);
    alu_valid = 1'b1; alu_rob_pos = 4'd0; alu_val = 32'hAA;
    step();
    idle();
    chk("br_rollback_drop", 32'(rollback), 32'd0);
    chk("br_no_commit", 32'(commit), 32'd0);
    chk("br_pos_zero", 32'(issue_rob_pos), 32'd0);
    chk("br_not_full", 32'(full), 32'd0);
    iss(5'd21, 1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    step();
    chk("post_rb_commit", 32'(commit), 32'd1);
    chk("post_rb_rd", 32'(commit_rd), 32'd21);
    chk("post_rb_val", commit_val, 32'h77);
    chk("post_rb_pos", 32'(commit_rob_pos), 32'd0);

    // Operand query bypass priority
    do_reset();
    for (int i = 0; i < 5; i++) iss(5'(i + 1), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    q1_rob_pos = 4'd4; q2_rob_pos = 4'd3;
    #1;
    chk("q1_not_ready", 32'(q1_ready), 32'd0);
    alu_valid = 1'b1; alu_rob_pos = 4'd4; alu_val = 32'hAB;
    #1;
    chk("q1_alu_bypass_rdy", 32'(q1_ready), 32'd1);
    chk("q1_alu_bypass_val", q1_val, 32'hAB);
    chk("q2_unrelated", 32'(q2_ready), 32'd0);
    step();
    alu_val = 32'hCD; lsb_valid = 1'b1; lsb_rob_pos = 4'd4; lsb_val = 32'hEF;
    #1;
    chk("q1_alu_over_lsb", q1_val, 32'hCD);
    step();
    idle();
    lsb_valid = 1'b1; lsb_rob_pos = 4'd3; lsb_val = 32'h33;
    #1;
    chk("q2_lsb_bypass_rdy", 32'(q2_ready), 32'd1);
    chk("q2_lsb_bypass_val", q2_val, 32'h33);
    chk("q1_stored_val", q1_val, 32'hCD);
    step();
    idle();

    // Store commit and rdy stall
    do_reset();
    iss(5'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    lsb_valid = 1'b1; lsb_rob_pos = 4'd0; lsb_val = 32'h0;
    step();
    idle();
    step();
    chk("st_commit", 32'(commit), 32'd1);
    chk("st_commit_store", 32'(commit_store), 32'd1);
    chk("st_commit_rd", 32'(commit_rd), 32'd0);
    rdy = 1'b0; issue = 1'b1; issue_rd = 5'd4; issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_commit", i), 32'(commit), 32'd1);
      chk($sformatf("stall%0d_store", i), 32'(commit_store), 32'd1);
      chk($sformatf("stall%0d_pos", i), 32'(issue_rob_pos), 32'd1);
    end
    idle();
    step();
    chk("unstall_commit", 32'(commit), 32'd0);
    chk("unstall_store", 32'(commit_store), 32'd0);
    chk("unstall_pos", 32'(issue_rob_pos), 32'd1);

    // Async reset while a commit pulse is pending
    do_reset();
    iss(5'd3, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
    step();
    chk("pre_rst_commit", 32'(commit), 32'd1);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
